// File: rtl/shift_rotate_unit.sv
// Two-stage pipelined shift/rotate unit: stage 1 moves by the even part of the
// amount, stage 2 by the remaining single bit and produces the registered flags.
module shift_rotate_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             zero
);

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SHR = 2'b10,
        OP_SAR = 2'b11
    } op_e;

    if (WIDTH != (2 ** SHW) || (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32)) begin : g_bad_params
        $error("shift_rotate_unit: WIDTH must be 4/8/16/32 and equal 2**SHW");
    end

    // Stage-1 registers
    logic             s1_valid;
    op_e              s1_op;
    logic             s1_b0;
    logic [WIDTH-1:0] s1_data;
    logic             s1_c1;

    // Stage-1 combinational datapath
    logic [SHW-1:0]     m;
    logic [SHW-1:0]     m_dec;
    logic [SHW-1:0]     m_neg;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [WIDTH-1:0]   s1_next;
    logic               c1_next;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        m       = {shamt[SHW-1:1], 1'b0};
        m_dec   = m - SHW'(1);
        m_neg   = SHW'(0) - m;    // WIDTH - m, modulo WIDTH
        dbl     = {data_in, data_in};
        ror_dbl = dbl >> m;
        rol_dbl = dbl << m;
        s1_next = data_in;
        c1_next = 1'b0;
        case (op_e'(op))
            OP_ROR: s1_next = ror_dbl[WIDTH-1:0];
            OP_ROL: s1_next = rol_dbl[2*WIDTH-1:WIDTH];
            OP_SHR: s1_next = data_in >> m;
            OP_SAR: s1_next = WIDTH'($signed(data_in) >>> m);
            default: s1_next = data_in;
        endcase
        if (m != '0) begin
            c1_next = (op_e'(op) == OP_ROL) ? data_in[m_neg] : data_in[m_dec];
        end
    end

    // Stage-2 combinational datapath: optional one-bit move plus carry select
    logic [WIDTH-1:0] s2_data;
    logic             s2_carry;

    always_comb begin
        s2_data  = s1_data;
        s2_carry = s1_c1;
        if (s1_b0) begin
            case (s1_op)
                OP_ROR: begin
                    s2_data  = {s1_data[0], s1_data[WIDTH-1:1]};
                    s2_carry = s1_data[0];
                end
                OP_ROL: begin
                    s2_data  = {s1_data[WIDTH-2:0], s1_data[WIDTH-1]};
                    s2_carry = s1_data[WIDTH-1];
                end
                OP_SHR: begin
                    s2_data  = {1'b0, s1_data[WIDTH-1:1]};
                    s2_carry = s1_data[0];
                end
                OP_SAR: begin
                    s2_data  = {s1_data[WIDTH-1], s1_data[WIDTH-1:1]};
                    s2_carry = s1_data[0];
                end
                default: begin
                    s2_data  = s1_data;
                    s2_carry = s1_c1;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments so stage 2 always sees stage 1's pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_ROR;
            s1_b0     <= 1'b0;
            s1_data   <= '0;
            s1_c1     <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only the qualifiers are dropped.
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else if (!data_hazard) begin
            s1_valid  <= in_valid;
            s1_op     <= op_e'(op);
            s1_b0     <= shamt[0];
            s1_data   <= s1_next;
            s1_c1     <= c1_next;
            out_valid <= s1_valid;
            data_out  <= s2_data;
            carry_out <= s2_carry;
            zero      <= s1_valid && (s2_data == '0);
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit (WIDTH = 8): latency, back-to-back
// throughput, zero/carry flags, stall, flush and mid-flight reset.
module tb_shift_rotate_unit;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_hazard;
    logic             flush;
    logic             in_valid;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;

    shift_rotate_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_hazard(data_hazard),
        .flush      (flush),
        .in_valid   (in_valid),
        .op         (op),
        .shamt      (shamt),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .carry_out  (carry_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [SHW-1:0] n, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        op       = o;
        shamt    = n;
        data_in  = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] d, input logic c, input logic z);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(data_out),  32'(d));
        check({tag, ".carry"}, 32'(carry_out), 32'(c));
        check({tag, ".zero"},  32'(zero),      32'(z));
    endtask

    // Isolated operation: present, wait two edges, compare.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [SHW-1:0] n,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d,
                          input logic exp_c, input logic exp_z);
        drive(o, n, d);
        step();
        idle();
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        step();
        check_out(tag, exp_d, exp_c, exp_z);
    endtask

    initial begin
        rst = 1'b1; data_hazard = 1'b0; flush = 1'b0;
        in_valid = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(data_out),  32'd0);
        check("rst.carry", 32'(carry_out), 32'd0);
        check("rst.zero",  32'(zero),      32'd0);
        rst = 1'b0;

        // First op right after reset release, plus directed single ops
        run_op("ror96_3",  2'b00, 3'd3, 8'h96, 8'hD2, 1'b1, 1'b0);
        run_op("shr01_1",  2'b10, 3'd1, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("rol96_7",  2'b01, 3'd7, 8'h96, 8'h4B, 1'b1, 1'b0);
        run_op("ror96_1",  2'b00, 3'd1, 8'h96, 8'h4B, 1'b0, 1'b0);
        run_op("sar80_7",  2'b11, 3'd7, 8'h80, 8'hFF, 1'b0, 1'b0);
        run_op("ror01_7",  2'b00, 3'd7, 8'h01, 8'h02, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op($sformatf("n0_op%0d", k), 2'(k), 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        end

        // Back-to-back: three results in consecutive cycles
        drive(2'b01, 3'd1, 8'h81);
        step();
        drive(2'b10, 3'd2, 8'h96);
        step();
        check_out("b2b_rol", 8'h03, 1'b1, 1'b0);
        drive(2'b11, 3'd4, 8'h96);
        step();
        check_out("b2b_shr", 8'h25, 1'b1, 1'b0);
        idle();
        step();
        check_out("b2b_sar", 8'hF9, 1'b0, 1'b0);
        step();
        check("b2b.drain", 32'(out_valid), 32'd0);

        // Stall: A captured, B held upstream while the pipe is frozen
        drive(2'b00, 3'd4, 8'hF0);
        step();
        drive(2'b10, 3'd1, 8'h80);
        data_hazard = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall1.valid%0d", k), 32'(out_valid), 32'd0);
        end
        data_hazard = 1'b0;
        step();
        check_out("stall_a", 8'h0F, 1'b0, 1'b0);
        drive(2'b11, 3'd2, 8'h33);
        data_hazard = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("stall2.valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("stall2.data%0d", k),  32'(data_out),  32'h0F);
        end
        data_hazard = 1'b0;
        idle();
        step();
        check_out("stall_b", 8'h40, 1'b0, 1'b0);
        step();
        check("stall.once", 32'(out_valid), 32'd0);

        // Flush together with stall: neither in-flight op may surface
        drive(2'b00, 3'd3, 8'h96);
        step();
        drive(2'b01, 3'd1, 8'h81);
        flush = 1'b1;
        data_hazard = 1'b1;
        step();
        flush = 1'b0;
        data_hazard = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush.valid%0d", k), 32'(out_valid), 32'd0);
            step();
        end
        run_op("post_flush", 2'b11, 3'd4, 8'h96, 8'hF9, 1'b0, 1'b0);

        // Reset one cycle after capture
        drive(2'b00, 3'd3, 8'h96);
        step();
        idle();
        rst = 1'b1;
        step();
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.data",  32'(data_out),  32'd0);
        check("mrst.carry", 32'(carry_out), 32'd0);
        check("mrst.zero",  32'(zero),      32'd0);
        rst = 1'b0;
        step();
        check("mrst.nopulse1", 32'(out_valid), 32'd0);
        step();
        check("mrst.nopulse2", 32'(out_valid), 32'd0);
        run_op("post_rst", 2'b10, 3'd2, 8'h96, 8'h25, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, datapath width in bits; legal values are 4, 8, 16 and 32.
REQ-002 The module SHALL take parameter SHW, default 3, shift-amount width; WIDTH SHALL equal 2**SHW, and any other combination is illegal.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port data_hazard, input, 1 bit: pipeline stall.
REQ-006 The module SHALL have port flush, input, 1 bit: discard all in-flight operations.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the operation on op/shamt/data_in is valid.
REQ-008 The module SHALL have port op, input, 2 bits: 00 ROR, 01 ROL, 10 SHR (logical right), 11 SAR (arithmetic right).
REQ-009 The module SHALL have port shamt, input, SHW bits: shift or rotate amount n, range 0..WIDTH-1.
REQ-010 The module SHALL have port data_in, input, WIDTH bits: operand.
REQ-011 The module SHALL have port out_valid, output, 1 bit: data_out, carry_out and zero hold a valid result.
REQ-012 The module SHALL have port data_out, output, WIDTH bits: result.
REQ-013 The module SHALL have port carry_out, output, 1 bit: last bit shifted or rotated out.
REQ-014 The module SHALL have port zero, output, 1 bit: high when data_out == 0 and out_valid is 1, else 0.

Function
REQ-015 The pipeline SHALL have two registered stages with a fixed latency of 2 clk edges and a throughput of one operation per cycle; all outputs SHALL be registered, with no combinational path from input to output.
REQ-016 Stage 1 SHALL capture op, shamt[0] and valid, and SHALL apply the shift or rotate by m = n with bit 0 cleared.
REQ-017 Stage 1 SHALL also register c1 = data_in[m-1] for right ops, data_in[WIDTH-m] for ROL, or 0 when m = 0.
REQ-018 Stage 2 SHALL apply the remaining shift or rotate by shamt[0] and SHALL drive data_out, carry_out, zero and out_valid.
REQ-019 ROR SHALL satisfy data_out = {data_in[n-1:0], data_in[WIDTH-1:n]}.
REQ-020 ROL SHALL satisfy data_out = {data_in[WIDTH-1-n:0], data_in[WIDTH-1:WIDTH-n]}.
REQ-021 SHR SHALL zero-fill the vacated MSBs.
REQ-022 SAR SHALL fill the vacated MSBs with data_in[WIDTH-1].
REQ-023 When n = 0, every op SHALL give data_out = data_in and carry_out = 0.
REQ-024 When n > 0, carry_out SHALL be: ROR -> data_out[WIDTH-1]; ROL -> data_out[0]; SHR/SAR -> data_in[n-1]. The stage-2 carry SHALL be taken from the stage-1 bit 0 (right ops) or bit WIDTH-1 (ROL) when shamt[0] = 1, else from c1.
REQ-025 With op = 00 and WIDTH = 8, the data_out result SHALL be bit-identical to the previous 8-bit right rotator; only the latency differs.
REQ-026 While data_hazard = 1, both stages SHALL hold all registers, and in_valid/data_in SHALL be ignored; the upstream stage holds its operands.
REQ-027 While flush = 1, both stage valid bits SHALL be cleared at the next edge; flush SHALL override data_hazard, and an operation presented with in_valid in the flush cycle SHALL be discarded.
REQ-028 When in_valid = 0, stage 1 SHALL capture valid = 0; data registers MAY update, but zero SHALL stay 0 while out_valid = 0.
REQ-029 Upstream SHALL keep shamt within 0..WIDTH-1; no out-of-range case exists by construction.

Reset
REQ-030 When rst = 1 at an edge, all stage registers, out_valid, data_out, carry_out and zero SHALL be 0 after that edge.
REQ-031 rst SHALL take priority over flush and data_hazard.
REQ-032 An operation in flight when rst asserts SHALL be lost, and out_valid SHALL never pulse for it.
REQ-033 The first operation accepted after rst deasserts SHALL appear exactly 2 edges later.

Verification (WIDTH = 8)
REQ-034 ROR 0x96, n = 3 -> data_out 0xD2, carry_out 1, zero 0, out_valid 2 edges after capture.
REQ-035 Back-to-back ops across three cycles -> the three outputs SHALL appear in consecutive cycles, with out_valid continuously high:
- ROL 0x81 n = 1 -> 0x03, carry_out 1.
- SHR 0x96 n = 2 -> 0x25, carry_out 1.
- SAR 0x96 n = 4 -> 0xF9, carry_out 0.
REQ-036 SHR 0x01 n = 1 -> data_out 0x00, carry_out 1, zero 1; any op with n = 0 on 0x5A -> data_out 0x5A, carry_out 0.
REQ-037 ROR 0xF0 n = 4 captured, then data_hazard high for 3 cycles -> outputs frozen during the stall, and result 0x0F appears 2 active (non-stalled) edges after capture, exactly once.
REQ-038 Two ops in flight, with flush asserted together with data_hazard -> out_valid 0 for both, and the next op proceeds normally.
REQ-039 rst pulsed one cycle after an op is captured -> all outputs 0, with no out_valid pulse for that op.
